// File: rtl/ni_vc_wb_slave_status_rd_pkg.sv
// Shared NI slave-window definitions: address map for both register banks,
// interrupt flag indices, STATUS bit positions and a ceiling-log2 helper.
package ni_vc_wb_slave_status_rd_pkg;

  // Read-side (status) addresses
  localparam int unsigned ADDR_STATUS       = 0;
  localparam int unsigned ADDR_IRQ_EN       = 1;
  localparam int unsigned ADDR_IRQ_FLAGS    = 2;
  localparam int unsigned ADDR_RCV_INFO     = 7;
  localparam int unsigned ADDR_RCV_SIZE     = 9;
  localparam int unsigned ADDR_SEND_PCK_CNT = 12;
  localparam int unsigned ADDR_RCV_PCK_CNT  = 13;

  // Addresses owned by the write-side register bank
  localparam int unsigned ADDR_WR_BANK_3  = 3;
  localparam int unsigned ADDR_WR_BANK_4  = 4;
  localparam int unsigned ADDR_WR_BANK_5  = 5;
  localparam int unsigned ADDR_WR_BANK_6  = 6;
  localparam int unsigned ADDR_WR_BANK_8  = 8;
  localparam int unsigned ADDR_WR_BANK_10 = 10;
  localparam int unsigned ADDR_WR_BANK_11 = 11;

  localparam int unsigned NFLAGS          = 4;
  localparam int unsigned FLAG_SEND_DONE  = 0;
  localparam int unsigned FLAG_RCV_DONE   = 1;
  localparam int unsigned FLAG_RCV_DISC   = 2;
  localparam int unsigned FLAG_OVERWRITE  = 3;

  localparam int unsigned STAT_SEND_IDLE  = 0;
  localparam int unsigned STAT_RCV_IDLE   = 1;
  localparam int unsigned STAT_VC_GOT_PCK = 2;
  localparam int unsigned STAT_PCK_SAVED  = 3;
  localparam int unsigned STAT_INFO_UNRD  = 4;

  localparam int unsigned INFO_CLASS_LSB  = 16;

  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ni_vc_wb_slave_status_rd_counter.sv
// Wrapping packet counter; a clear coinciding with an increment yields 1.
module ni_event_counter #(
  parameter int CNTw = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CNTw-1:0] cnt_o
);

  logic [CNTw-1:0] cnt_q;
  logic [CNTw-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? {{(CNTw-1){1'b0}}, 1'b1} : {CNTw{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(CNTw-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNTw{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ni_vc_wb_slave_status_rd.sv
// Wishbone read responder and ack generator for the NI slave window:
// status, received-packet info, packet counters and interrupt flags.
module ni_vc_wb_slave_status_rd
  import ni_vc_wb_slave_status_rd_pkg::*;
#(
  parameter int MAX_TRANSACTION_WIDTH = 10,
  parameter int EAw  = 4,
  parameter int C    = 4,
  parameter int Cw   = (C > 1) ? log2(C) : 1,
  parameter int CNTw = 16,
  parameter int Dw   = 32,
  parameter int S_Aw = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [Dw-1:0]                    s_dat_i,
  input  logic [S_Aw-1:0]                  s_addr_i,
  input  logic                             s_stb_i,
  input  logic                             s_cyc_i,
  input  logic                             s_we_i,
  output logic [Dw-1:0]                    s_dat_o,
  output logic                             s_ack_o,
  input  logic                             send_fsm_is_ideal,
  input  logic                             receive_fsm_is_ideal,
  input  logic                             receive_vc_got_packet,
  input  logic                             receive_packet_is_saved,
  input  logic                             send_done,
  input  logic                             receive_done,
  input  logic                             rcv_discard,
  input  logic [EAw-1:0]                   rcv_src_e_addr,
  input  logic [Cw-1:0]                    rcv_pck_class,
  input  logic [MAX_TRANSACTION_WIDTH-1:0] rcv_pck_size,
  output logic                             irq
);

  logic                             ack_q, ack_d;
  logic [Dw-1:0]                    dat_q, dat_d;
  logic                             irq_q, irq_d;
  logic [NFLAGS-1:0]                irq_en_q, irq_en_d;
  logic [NFLAGS-1:0]                flags_q, flags_d;
  logic [EAw-1:0]                   info_src_q, info_src_d;
  logic [Cw-1:0]                    info_class_q, info_class_d;
  logic [MAX_TRANSACTION_WIDTH-1:0] info_size_q, info_size_d;
  logic                             info_unread_q, info_unread_d;

  logic              acc_s, rd_s, wr_s;
  logic [Dw-1:0]     rd_data_s;
  logic [NFLAGS-1:0] flag_set_s, flag_clr_s;
  logic              clr_send_cnt_s, clr_rcv_cnt_s;
  logic [CNTw-1:0]   send_cnt_s, rcv_cnt_s;

  // The ack cycle is the only cycle in which an access takes effect
  assign acc_s = s_stb_i & s_cyc_i & ~ack_q;
  assign rd_s  = acc_s & ~s_we_i;
  assign wr_s  = acc_s & s_we_i;

  assign clr_send_cnt_s = wr_s && (s_addr_i == S_Aw'(ADDR_SEND_PCK_CNT));
  assign clr_rcv_cnt_s  = wr_s && (s_addr_i == S_Aw'(ADDR_RCV_PCK_CNT));

  ni_event_counter #(.CNTw(CNTw)) u_send_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (send_done),
    .clr_i (clr_send_cnt_s),
    .cnt_o (send_cnt_s)
  );

  ni_event_counter #(.CNTw(CNTw)) u_rcv_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (receive_done),
    .clr_i (clr_rcv_cnt_s),
    .cnt_o (rcv_cnt_s)
  );

  // Read mux sees pre-update state so reads return the value before same-cycle events
  always_comb begin
    rd_data_s = {Dw{1'b0}};
    case (s_addr_i)
      S_Aw'(ADDR_STATUS): begin
        rd_data_s[STAT_SEND_IDLE]  = send_fsm_is_ideal;
        rd_data_s[STAT_RCV_IDLE]   = receive_fsm_is_ideal;
        rd_data_s[STAT_VC_GOT_PCK] = receive_vc_got_packet;
        rd_data_s[STAT_PCK_SAVED]  = receive_packet_is_saved;
        rd_data_s[STAT_INFO_UNRD]  = info_unread_q;
      end
      S_Aw'(ADDR_IRQ_EN):       rd_data_s[NFLAGS-1:0] = irq_en_q;
      S_Aw'(ADDR_IRQ_FLAGS):    rd_data_s[NFLAGS-1:0] = flags_q;
      S_Aw'(ADDR_RCV_INFO): begin
        rd_data_s[EAw-1:0]              = info_src_q;
        rd_data_s[INFO_CLASS_LSB +: Cw] = info_class_q;
      end
      S_Aw'(ADDR_RCV_SIZE):     rd_data_s = Dw'(info_size_q);
      S_Aw'(ADDR_SEND_PCK_CNT): rd_data_s = Dw'(send_cnt_s);
      S_Aw'(ADDR_RCV_PCK_CNT):  rd_data_s = Dw'(rcv_cnt_s);
      default:                  rd_data_s = {Dw{1'b0}};
    endcase
  end

  always_comb begin
    flag_set_s                 = {NFLAGS{1'b0}};
    flag_set_s[FLAG_SEND_DONE] = send_done;
    flag_set_s[FLAG_RCV_DONE]  = receive_done;
    flag_set_s[FLAG_RCV_DISC]  = rcv_discard;
    flag_set_s[FLAG_OVERWRITE] = receive_done & info_unread_q;
    flag_clr_s = (wr_s && (s_addr_i == S_Aw'(ADDR_IRQ_FLAGS))) ? s_dat_i[NFLAGS-1:0]
                                                               : {NFLAGS{1'b0}};
    ack_d    = s_stb_i & s_cyc_i & ~ack_q;
    dat_d    = rd_s ? rd_data_s : dat_q;
    irq_en_d = (wr_s && (s_addr_i == S_Aw'(ADDR_IRQ_EN))) ? s_dat_i[NFLAGS-1:0] : irq_en_q;
    // Set has priority over a same-cycle W1C
    flags_d  = (flags_q & ~flag_clr_s) | flag_set_s;
    irq_d    = |(flags_d & irq_en_d);
    if (receive_done) begin
      info_src_d    = rcv_src_e_addr;
      info_class_d  = rcv_pck_class;
      info_size_d   = rcv_pck_size;
      info_unread_d = 1'b1;
    end else begin
      info_src_d    = info_src_q;
      info_class_d  = info_class_q;
      info_size_d   = info_size_q;
      info_unread_d = (rd_s && (s_addr_i == S_Aw'(ADDR_RCV_INFO))) ? 1'b0 : info_unread_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q         <= 1'b0;
      dat_q         <= {Dw{1'b0}};
      irq_q         <= 1'b0;
      irq_en_q      <= {NFLAGS{1'b0}};
      flags_q       <= {NFLAGS{1'b0}};
      info_src_q    <= {EAw{1'b0}};
      info_class_q  <= {Cw{1'b0}};
      info_size_q   <= {MAX_TRANSACTION_WIDTH{1'b0}};
      info_unread_q <= 1'b0;
    end else begin
      ack_q         <= ack_d;
      dat_q         <= dat_d;
      irq_q         <= irq_d;
      irq_en_q      <= irq_en_d;
      flags_q       <= flags_d;
      info_src_q    <= info_src_d;
      info_class_q  <= info_class_d;
      info_size_q   <= info_size_d;
      info_unread_q <= info_unread_d;
    end
  end

  assign s_ack_o = ack_q;
  assign s_dat_o = dat_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_ni_vc_wb_slave_status_rd.sv
// Scoreboard bench for the NI slave-window read responder.
module tb_ni_vc_wb_slave_status_rd;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_dat_i;
  logic [3:0]  s_addr_i;
  logic        s_stb_i, s_cyc_i, s_we_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        send_fsm_is_ideal, receive_fsm_is_ideal;
  logic        receive_vc_got_packet, receive_packet_is_saved;
  logic        send_done, receive_done, rcv_discard;
  logic [3:0]  rcv_src_e_addr;
  logic [1:0]  rcv_pck_class;
  logic [9:0]  rcv_pck_size;
  logic        irq;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ni_vc_wb_slave_status_rd dut (
    .clk                     (clk),
    .reset                   (reset),
    .s_dat_i                 (s_dat_i),
    .s_addr_i                (s_addr_i),
    .s_stb_i                 (s_stb_i),
    .s_cyc_i                 (s_cyc_i),
    .s_we_i                  (s_we_i),
    .s_dat_o                 (s_dat_o),
    .s_ack_o                 (s_ack_o),
    .send_fsm_is_ideal       (send_fsm_is_ideal),
    .receive_fsm_is_ideal    (receive_fsm_is_ideal),
    .receive_vc_got_packet   (receive_vc_got_packet),
    .receive_packet_is_saved (receive_packet_is_saved),
    .send_done               (send_done),
    .receive_done            (receive_done),
    .rcv_discard             (rcv_discard),
    .rcv_src_e_addr          (rcv_src_e_addr),
    .rcv_pck_class           (rcv_pck_class),
    .rcv_pck_size            (rcv_pck_size),
    .irq                     (irq)
  );

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one scoreboard entry; reads compare the data
  always @(negedge clk) begin
    if (s_ack_o === 1'b1 && reset === 1'b0) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk) begin
          check(s_dat_o, e.exp, e.name);
        end
      end
    end
  end

  task automatic wb(input logic we, input logic [3:0] addr, input logic [31:0] wdat,
                    input logic [31:0] exp, input string name,
                    input logic ev_send, input logic ev_rcv);
    exp_t e;
    @(negedge clk);
    e.chk = !we; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    s_stb_i = 1'b1; s_cyc_i = 1'b1; s_we_i = we; s_addr_i = addr; s_dat_i = wdat;
    send_done = ev_send; receive_done = ev_rcv;
    @(posedge clk); #1;
    send_done = 1'b0; receive_done = 1'b0;
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    check({31'd0, s_ack_o}, 32'd1, {name, "_ack"});
    @(posedge clk); #1;
    check({31'd0, s_ack_o}, 32'd0, {name, "_ack_drop"});
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
    wb(1'b0, addr, 32'd0, exp, name, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wdat, input string name);
    wb(1'b1, addr, wdat, 32'd0, name, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic s, input logic r, input logic d, input int n);
    @(negedge clk);
    send_done = s; receive_done = r; rcv_discard = d;
    repeat (n) @(posedge clk);
    #1;
    send_done = 1'b0; receive_done = 1'b0; rcv_discard = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s_dat_i = 32'd0; s_addr_i = 4'd0; s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    send_fsm_is_ideal = 1'b1; receive_fsm_is_ideal = 1'b1;
    receive_vc_got_packet = 1'b0; receive_packet_is_saved = 1'b0;
    send_done = 1'b0; receive_done = 1'b0; rcv_discard = 1'b0;
    rcv_src_e_addr = 4'd0; rcv_pck_class = 2'd0; rcv_pck_size = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check({31'd0, s_ack_o}, 32'd0, "reset_ack");
    check(s_dat_o, 32'd0, "reset_dat");
    check({31'd0, irq}, 32'd0, "reset_irq");
    @(negedge clk);
    reset = 1'b0;

    rd(4'd0, 32'h3, "status_idle");
    receive_vc_got_packet = 1'b1; receive_packet_is_saved = 1'b1;
    rd(4'd0, 32'hF, "status_all_levels");
    receive_vc_got_packet = 1'b0; receive_packet_is_saved = 1'b0;

    rcv_src_e_addr = 4'h5; rcv_pck_class = 2'd2; rcv_pck_size = 10'd37;
    pulse(1'b0, 1'b1, 1'b0, 1);
    rd(4'd0, 32'h13, "status_unread");
    rd(4'd7, 32'h0002_0005, "rcv_info");
    rd(4'd9, 32'd37, "rcv_size");
    rd(4'd0, 32'h3, "status_after_info_rd");
    rd(4'd2, 32'h2, "flags_rcv_done");

    wr(4'd1, 32'h8, "wr_irq_en");
    rd(4'd1, 32'h8, "irq_en");
    pulse(1'b0, 1'b1, 1'b0, 2);
    rd(4'd2, 32'hA, "flags_overwrite");
    check({31'd0, irq}, 32'd1, "irq_overwrite");
    wr(4'd2, 32'h8, "w1c_overwrite");
    check({31'd0, irq}, 32'd0, "irq_after_w1c");
    rd(4'd2, 32'h2, "flags_after_w1c");
    rd(4'd7, 32'h0002_0005, "rcv_info_again");
    wr(4'd2, 32'h2, "w1c_rcv_done");
    rd(4'd2, 32'h0, "flags_clear");

    pulse(1'b1, 1'b0, 1'b0, 1);
    wb(1'b1, 4'd2, 32'h1, 32'd0, "w1c_vs_set", 1'b1, 1'b0);
    rd(4'd2, 32'h1, "flags_set_wins");
    wr(4'd2, 32'h1, "w1c_send");
    rd(4'd2, 32'h0, "flags_send_clear");
    wb(1'b0, 4'd12, 32'd0, 32'd2, "send_cnt_pre_inc", 1'b1, 1'b0);
    rd(4'd12, 32'd3, "send_cnt_post_inc");
    wr(4'd12, 32'd0, "clr_send_cnt");
    rd(4'd12, 32'd0, "send_cnt_cleared");
    rd(4'd13, 32'd3, "rcv_cnt");

    pulse(1'b1, 1'b0, 1'b0, 65536);
    rd(4'd12, 32'd0, "send_cnt_wrap");
    wb(1'b1, 4'd12, 32'd0, 32'd0, "clr_with_inc", 1'b1, 1'b0);
    rd(4'd12, 32'd1, "send_cnt_clr_inc");
    pulse(1'b0, 1'b0, 1'b1, 1);
    rd(4'd2, 32'h5, "flags_discard");
    rd(4'd5, 32'h0, "unmapped_5");
    rd(4'd15, 32'h0, "unmapped_15");
    wr(4'd1, 32'hF, "wr_irq_en_all");
    check({31'd0, irq}, 32'd1, "irq_all_en");

    wr(4'd12, 32'd0, "clr_send_7");
    wr(4'd13, 32'd0, "clr_rcv_7");
    pulse(1'b1, 1'b1, 1'b0, 7);
    rd(4'd12, 32'd7, "send_cnt_7");
    rd(4'd13, 32'd7, "rcv_cnt_7");

    @(negedge clk);
    s_stb_i = 1'b1; s_cyc_i = 1'b1; s_we_i = 1'b0; s_addr_i = 4'd12;
    @(posedge clk); #1;
    check({31'd0, s_ack_o}, 32'd1, "pre_reset_ack");
    reset = 1'b1;
    #1;
    check({31'd0, s_ack_o}, 32'd0, "mid_reset_ack");
    check(s_dat_o, 32'd0, "mid_reset_dat");
    check({31'd0, irq}, 32'd0, "mid_reset_irq");
    s_stb_i = 1'b0; s_cyc_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd(4'd12, 32'd0, "send_cnt_after_reset");
    rd(4'd13, 32'd0, "rcv_cnt_after_reset");
    rd(4'd1, 32'd0, "irq_en_after_reset");
    rd(4'd2, 32'd0, "flags_after_reset");

    repeat (2) @(posedge clk);
    check(sb_q.size(), 32'd0, "scoreboard_drained");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
